bank_mapper: RTL and testbench

- Write side and lookup side of the 16-entry SRAM bank mapper.
- Lookup side feeds the memory interface: takes its bank_sel and returns bank_mapped, bank_readonly and bank_address in the same cycle.
- Write side is a memory-mapped register window. The host CPU programs it with byte writes while mm_enable is asserted, and reads it back through the host data bus.
- A CRU-driven map_enable selects between the programmed map and the fixed identity map.

---
 rtl/bank_mapper.sv | 170 +++++++++++++++++
 tb/tb_bank_mapper.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_mapper.sv
// bank_mapper: 16-entry SRAM bank map with host register window.
// Lookup and readback are combinational; host byte writes go through a small FSM.
module bank_mapper #(
  parameter int NUM_BANKS = 16,
  parameter int PAGE_BITS = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  output logic                         bank_mapped,
  output logic                         bank_readonly,
  output logic [PAGE_BITS-1:0]         bank_address,
  input  logic                         map_enable,
  input  logic                         mm_enable,
  input  logic [15:0]                  address_bus,
  input  logic [7:0]                   data_bus,
  input  logic                         dbin,
  input  logic                         we,
  input  logic                         a15,
  output logic [7:0]                   mm_data_out,
  output logic                         mm_data_oe
);

  localparam int IW = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_LO,
    W_COMMIT
  } wstate_t;

  wstate_t state;

  logic [NUM_BANKS-1:0] map_v;
  logic [NUM_BANKS-1:0] map_ro;
  logic [PAGE_BITS-1:0] map_pg [NUM_BANKS];

  logic we_s1, we_s2, we_s3;
  logic we_rise, rise_held, rise_any, wr_ok;

  logic [7:0]           lo_hold;
  logic [IW-1:0]        idx_hold;
  logic                 off_cnt;
  logic                 stg_v, stg_ro;
  logic [PAGE_BITS-1:0] stg_pg;
  logic [IW-1:0]        stg_idx;

  logic [IW-1:0]        idx;
  logic [PAGE_BITS-1:0] cur_pg;
  logic [7:0]           rd_hi, rd_lo;
  logic                 unused_bits;

  assign idx      = address_bus[IW:1];
  assign cur_pg   = map_pg[idx];
  assign we_rise  = we_s2 & ~we_s3;
  assign rise_any = we_rise | rise_held;
  assign wr_ok    = mm_enable & ~dbin;

  assign unused_bits = ^{address_bus[15:IW+1], address_bus[0], lo_hold[7]};

  // Lookup: programmed map, or identity when the CRU disables mapping.
  always_comb begin
    bank_mapped   = 1'b1;
    bank_readonly = 1'b0;
    bank_address  = PAGE_BITS'(bank_sel);
    if (map_enable) begin
      bank_mapped   = map_v[bank_sel];
      bank_readonly = map_ro[bank_sel];
      bank_address  = map_pg[bank_sel];
    end
  end

  // Readback: odd byte carries page, even byte carries flags.
  always_comb begin
    rd_hi       = {map_v[idx], map_ro[idx], 6'b0};
    rd_lo       = 8'(map_pg[idx]);
    mm_data_oe  = reset & mm_enable & dbin;
    mm_data_out = 8'h00;
    if (mm_data_oe) mm_data_out = a15 ? rd_lo : rd_hi;
  end

  // Bring the asynchronous host strobe into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_s1 <= 1'b0;
      we_s2 <= 1'b0;
      we_s3 <= 1'b0;
    end else begin
      we_s1 <= we;
      we_s2 <= we_s1;
      we_s3 <= we_s2;
    end
  end

  // Byte-pairing write FSM; a strobe during commit is held for idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= W_IDLE;
      lo_hold   <= 8'h00;
      idx_hold  <= '0;
      off_cnt   <= 1'b0;
      rise_held <= 1'b0;
      stg_v     <= 1'b0;
      stg_ro    <= 1'b0;
      stg_pg    <= '0;
      stg_idx   <= '0;
    end else begin
      unique case (state)
        W_IDLE: begin
          rise_held <= 1'b0;
          if (rise_any && wr_ok) begin
            if (a15) begin
              lo_hold  <= data_bus;
              idx_hold <= idx;
              off_cnt  <= 1'b0;
              state    <= W_HAVE_LO;
            end else begin
              stg_v   <= data_bus[7];
              stg_ro  <= data_bus[6];
              stg_pg  <= cur_pg;
              stg_idx <= idx;
              state   <= W_COMMIT;
            end
          end
        end
        W_HAVE_LO: begin
          if (rise_any && wr_ok) begin
            if (a15) begin
              lo_hold  <= data_bus;
              idx_hold <= idx;
              off_cnt  <= 1'b0;
            end else begin
              stg_v   <= data_bus[7];
              stg_ro  <= data_bus[6];
              stg_pg  <= (idx == idx_hold) ? lo_hold[PAGE_BITS-1:0] : cur_pg;
              stg_idx <= idx;
              state   <= W_COMMIT;
            end
          end else if (!mm_enable) begin
            off_cnt <= ~off_cnt;
            if (off_cnt) state <= W_IDLE;
          end else begin
            off_cnt <= 1'b0;
          end
        end
        W_COMMIT: begin
          rise_held <= we_rise;
          state     <= W_IDLE;
        end
        default: state <= W_IDLE;
      endcase
    end
  end

  // Map storage: identity on reset, one entry updated per commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        map_v[i]  <= 1'b1;
        map_ro[i] <= 1'b0;
        map_pg[i] <= PAGE_BITS'(i);
      end
    end else if (state == W_COMMIT) begin
      map_v[stg_idx]  <= stg_v;
      map_ro[stg_idx] <= stg_ro;
      map_pg[stg_idx] <= stg_pg;
    end
  end

endmodule

// File: tb/tb_bank_mapper.sv
// tb_bank_mapper: directed plan plus random host traffic,
// checked every cycle against a transaction-level map model.
module tb_bank_mapper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  bank_sel = '0;
  logic        bank_mapped, bank_readonly;
  logic [6:0]  bank_address;
  logic        map_enable = 1'b1;
  logic        mm_enable = 1'b0;
  logic [15:0] address_bus = '0;
  logic [7:0]  data_bus = '0;
  logic        dbin = 1'b0;
  logic        we = 1'b0;
  logic        a15 = 1'b0;
  logic [7:0]  mm_data_out;
  logic        mm_data_oe;

  bank_mapper dut (
    .clk(clk), .reset(reset), .bank_sel(bank_sel),
    .bank_mapped(bank_mapped), .bank_readonly(bank_readonly),
    .bank_address(bank_address), .map_enable(map_enable),
    .mm_enable(mm_enable), .address_bus(address_bus),
    .data_bus(data_bus), .dbin(dbin), .we(we), .a15(a15),
    .mm_data_out(mm_data_out), .mm_data_oe(mm_data_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit running = 0;
  bit rand_sel = 0;

  typedef struct {
    int         fire;
    logic [3:0] idx;
    logic       a15;
    logic [7:0] data;
    logic       mm;
    logic       dbin;
  } wr_t;

  logic [15:0] ment [16];
  wr_t         wq [$];
  int          cyc = 0;
  bit          cm_v;
  int          cm_cyc;
  logic [3:0]  cm_idx;
  logic [15:0] cm_val;
  bit          lo_v;
  logic [3:0]  lo_idx;
  logic [7:0]  lo_val;
  int          lo_off;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_lookup(input string name, input logic [15:0] e);
    chk({name, "_mapped"}, 16'(bank_mapped), 16'(e[15]));
    chk({name, "_ro"}, 16'(bank_readonly), 16'(e[14]));
    chk({name, "_addr"}, 16'(bank_address), 16'(e[6:0]));
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) ment[i] = 16'h8000 | 16'(i);
    wq.delete();
    cm_v = 0;
    lo_v = 0;
    lo_off = 0;
  endfunction

  // One clock of the model: apply due commit, then due host write or timeout.
  task automatic model_step();
    bit   wrote;
    wr_t  w;
    logic [7:0] lo;
    wrote = 0;
    if (cm_v && cm_cyc == cyc) begin
      ment[cm_idx] = cm_val;
      cm_v = 0;
    end
    if (wq.size() > 0 && wq[0].fire == cyc) begin
      w = wq.pop_front();
      if (w.mm && !w.dbin) begin
        wrote = 1;
        if (w.a15) begin
          lo_v = 1; lo_idx = w.idx; lo_val = w.data; lo_off = 0;
        end else begin
          lo = (lo_v && lo_idx == w.idx) ? lo_val : ment[w.idx][7:0];
          lo_v = 0;
          cm_v = 1; cm_cyc = cyc + 1; cm_idx = w.idx;
          cm_val = {w.data, lo} & 16'hC07F;
        end
      end
    end
    if (!wrote && lo_v) begin
      if (!mm_enable) begin
        lo_off++;
        if (lo_off >= 2) lo_v = 0;
      end else lo_off = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else begin
        cyc++;
        model_step();
      end
    end
  end

  // Per-cycle comparison of lookup and readback against the model.
  initial begin
    logic [15:0] e;
    logic [15:0] r;
    logic        oe;
    forever begin
      @(negedge clk);
      if (running) begin
        e = map_enable ? ment[bank_sel] : (16'h8000 | 16'(bank_sel));
        chk_lookup("cyc", e);
        r  = ment[address_bus[4:1]];
        oe = reset & mm_enable & dbin;
        chk("cyc_oe", 16'(mm_data_oe), 16'(oe));
        chk("cyc_rd", 16'(mm_data_out), oe ? 16'(a15 ? r[7:0] : r[15:8]) : 16'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_sel) begin
      bank_sel   = 4'($urandom);
      map_enable = ($urandom % 4) != 0;
    end
  endtask

  task automatic host_write(input logic [3:0] idx, input logic a15v, input logic [7:0] d,
                            input logic mm = 1'b1, input logic db = 1'b0,
                            input bit probe = 0, input logic [15:0] pold = '0,
                            input logic [15:0] pnew = '0);
    wr_t w;
    @(posedge clk);
    #1;
    address_bus = 16'($urandom);
    address_bus[4:1] = idx;
    data_bus = d; a15 = a15v; mm_enable = mm; dbin = db; we = 1'b1;
    w.fire = cyc + 3; w.idx = idx; w.a15 = a15v; w.data = d; w.mm = mm; w.dbin = db;
    wq.push_back(w);
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 3) we = 1'b0;
      if (probe && k == 2) chk_lookup("commit_old", pold);
      if (probe && k == 3) chk_lookup("commit_new", pnew);
    end
  endtask

  task automatic readback(input string name, input logic [3:0] idx, input logic [15:0] e);
    mm_enable = 1'b1; dbin = 1'b1;
    address_bus = {11'b0, idx, 1'b0};
    a15 = 1'b0;
    #1 chk({name, "_hi"}, 16'(mm_data_out), 16'(e[15:8]));
    a15 = 1'b1;
    #1 chk({name, "_lo"}, 16'(mm_data_out), 16'(e[7:0]));
    dbin = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    running = 1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 bank_sel = 4'(i);
      #1 chk_lookup("reset_sweep", 16'h8000 | 16'(i));
    end

    bank_sel = 4'd3;
    host_write(4'd3, 1'b1, 8'h25);
    host_write(4'd3, 1'b0, 8'hC0);
    #1 chk_lookup("reg3", 16'hC025);
    readback("reg3_rd", 4'd3, 16'hC025);

    host_write(4'd5, 1'b1, 8'h11);
    mm_enable = 1'b0;
    repeat (3) tick();
    host_write(4'd5, 1'b0, 8'h80);
    readback("reg5_rd", 4'd5, 16'h8005);

    host_write(4'd7, 1'b1, 8'h12);
    host_write(4'd7, 1'b0, 8'h00);
    map_enable = 1'b0; bank_sel = 4'd7;
    #1 chk_lookup("reg7_ident", 16'h8007);
    map_enable = 1'b1;
    #1 chk_lookup("reg7_map", 16'h0012);

    bank_sel = 4'd2;
    host_write(4'd2, 1'b0, 8'hFF, 1'b1, 1'b0, 1, 16'h8002, 16'hC002);
    readback("reg2_rd", 4'd2, 16'hC002);

    host_write(4'd9, 1'b1, 8'h33);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    bank_sel = 4'd9;
    #1 chk_lookup("reg9_reset", 16'h8009);
    host_write(4'd9, 1'b0, 8'h40);
    #1 chk_lookup("reg9_lone", 16'h4009);

    rand_sel = 1;
    repeat (200) begin
      if (($urandom % 10) < 6) begin
        host_write(4'($urandom % 6), 1'($urandom), 8'($urandom),
                   ($urandom % 8) != 0, ($urandom % 8) == 0);
      end else begin
        repeat (1 + $urandom % 4) begin
          tick();
          mm_enable = 1'($urandom);
          dbin = 1'($urandom);
          a15 = 1'($urandom);
          address_bus = 16'($urandom);
        end
      end
    end

    running = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
